// File: rtl/rv32_pkg.sv
// Shared RV32I encodings used by the memory stage and its lane generator.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Loads accept the signed and unsigned sub-word widths; stores only B/H/W.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    if (is_store) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Combinational store lane builder: replicates store data across byte lanes,
// produces byte enables and flags accesses misaligned for their width.
module store_lane_gen
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rv2,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned
);

  // funct3[1:0] encodes access width for both loads and stores.
  always_comb begin
    wdata      = rv2;
    be         = 4'b0000;
    misaligned = 1'b0;
    unique case (funct3[1:0])
      2'b00: begin
        wdata = {4{rv2[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      2'b01: begin
        wdata      = {2{rv2[15:0]}};
        be         = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
      end
      2'b10: begin
        wdata      = rv2;
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      default: begin
        wdata = rv2;
        be    = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I memory stage: issues data-memory requests over req/ack, stalls the
// front of the pipeline while memory is busy, and fills the MEM/WB register.
module mem_access_stage
  import rv32_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EM_valid_out,
  input  logic [6:0]  EM_op_out,
  input  logic [2:0]  EM_funct3_out,
  input  logic [31:0] EM_daddr_out,
  input  logic [31:0] EM_rv2_out,
  input  logic [31:0] EM_regdata_out,
  input  logic [4:0]  EM_rd_out,
  output logic        dreq,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata,
  input  logic        dack,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic        MW_valid_out,
  output logic [6:0]  MW_op_out,
  output logic [2:0]  MW_funct3_out,
  output logic [31:0] MW_daddr_out,
  output logic [31:0] MW_drdata_out,
  output logic [31:0] MW_regdata_out,
  output logic [4:0]  MW_rd_out
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  mem_state_e  state;
  logic [7:0]  wait_cnt;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        f3_ok;
  logic        misal;
  logic        bad_op;
  logic        good_op;
  logic        in_idle;
  logic        in_wait;
  logic        timeout;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;

  store_lane_gen u_lane (
    .funct3     (EM_funct3_out),
    .addr_lo    (EM_daddr_out[1:0]),
    .rv2        (EM_rv2_out),
    .wdata      (lane_wdata),
    .be         (lane_be),
    .misaligned (misal)
  );

  // Decode the EX/MEM slot and derive the request/stall handshake.
  always_comb begin
    is_load   = (EM_op_out == OP_LOAD);
    is_store  = (EM_op_out == OP_STORE);
    is_mem    = is_load || is_store;
    f3_ok     = f3_legal(is_store, EM_funct3_out);
    bad_op    = EM_valid_out && is_mem && (!f3_ok || misal);
    good_op   = EM_valid_out && is_mem && f3_ok && !misal;
    in_idle   = (state == IDLE);
    in_wait   = (state == WAIT);
    // The cycle that hits the limit releases the pipeline instead of stalling.
    timeout   = in_wait && !dack && (wait_cnt == MAX_CNT);
    dreq      = in_wait || (in_idle && good_op);
    mem_stall = dreq && !dack && !timeout;
    daddr     = {EM_daddr_out[31:2], 2'b00};
    dwdata    = lane_wdata;
    dwe       = (dreq && is_store) ? lane_be : 4'b0000;
  end

  // MEM/WB boundary: FSM, wait counter, fault pulse and the MW_* register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= 8'd0;
      mem_fault      <= 1'b0;
      MW_valid_out   <= 1'b0;
      MW_op_out      <= 7'd0;
      MW_funct3_out  <= 3'd0;
      MW_daddr_out   <= 32'd0;
      MW_drdata_out  <= 32'd0;
      MW_regdata_out <= 32'd0;
      MW_rd_out      <= 5'd0;
    end else begin
      mem_fault      <= (in_idle && bad_op) || timeout;
      // EM_* is held stable across a stall, so copying it every cycle is safe;
      // only MW_valid_out decides whether downstream acts on it.
      MW_op_out      <= EM_op_out;
      MW_funct3_out  <= EM_funct3_out;
      MW_daddr_out   <= EM_daddr_out;
      MW_regdata_out <= EM_regdata_out;
      MW_rd_out      <= EM_rd_out;
      unique case (state)
        IDLE: begin
          if (bad_op) begin
            MW_valid_out <= 1'b0;
          end else if (good_op) begin
            if (dack) begin
              MW_valid_out  <= 1'b1;
              MW_drdata_out <= drdata;
            end else begin
              MW_valid_out <= 1'b0;
              wait_cnt     <= 8'd1;
              state        <= WAIT;
            end
          end else begin
            MW_valid_out <= EM_valid_out;
          end
        end
        WAIT: begin
          if (dack) begin
            MW_valid_out  <= 1'b1;
            MW_drdata_out <= drdata;
            wait_cnt      <= 8'd0;
            state         <= IDLE;
          end else if (timeout) begin
            MW_valid_out <= 1'b0;
            wait_cnt     <= 8'd0;
            state        <= IDLE;
          end else begin
            MW_valid_out <= 1'b0;
            wait_cnt     <= wait_cnt + 8'd1;
          end
        end
        default: begin
          MW_valid_out <= 1'b0;
          wait_cnt     <= 8'd0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage (built with MAX_WAIT=4).
module tb_mem_access_stage;
  import rv32_pkg::*;

  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic        clk;
  logic        reset;
  logic        EM_valid_out;
  logic [6:0]  EM_op_out;
  logic [2:0]  EM_funct3_out;
  logic [31:0] EM_daddr_out;
  logic [31:0] EM_rv2_out;
  logic [31:0] EM_regdata_out;
  logic [4:0]  EM_rd_out;
  logic        dreq;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic        dack;
  logic        mem_stall;
  logic        mem_fault;
  logic        MW_valid_out;
  logic [6:0]  MW_op_out;
  logic [2:0]  MW_funct3_out;
  logic [31:0] MW_daddr_out;
  logic [31:0] MW_drdata_out;
  logic [31:0] MW_regdata_out;
  logic [4:0]  MW_rd_out;

  mem_access_stage #(.MAX_WAIT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .EM_valid_out   (EM_valid_out),
    .EM_op_out      (EM_op_out),
    .EM_funct3_out  (EM_funct3_out),
    .EM_daddr_out   (EM_daddr_out),
    .EM_rv2_out     (EM_rv2_out),
    .EM_regdata_out (EM_regdata_out),
    .EM_rd_out      (EM_rd_out),
    .dreq           (dreq),
    .daddr          (daddr),
    .dwdata         (dwdata),
    .dwe            (dwe),
    .drdata         (drdata),
    .dack           (dack),
    .mem_stall      (mem_stall),
    .mem_fault      (mem_fault),
    .MW_valid_out   (MW_valid_out),
    .MW_op_out      (MW_op_out),
    .MW_funct3_out  (MW_funct3_out),
    .MW_daddr_out   (MW_daddr_out),
    .MW_drdata_out  (MW_drdata_out),
    .MW_regdata_out (MW_regdata_out),
    .MW_rd_out      (MW_rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        full;
    logic        v;
    logic        fault;
    logic        chk_rdata;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] regdata;
    logic [4:0]  rd;
  } mw_t;

  mw_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mw_t bub(input logic fault);
    mw_t e;
    e = '0;
    e.fault = fault;
    return e;
  endfunction

  function automatic mw_t zero_rec();
    mw_t e;
    e = '0;
    e.full = 1'b1;
    return e;
  endfunction

  function automatic mw_t live(input logic [6:0] op, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] rdata,
                               input logic chkr, input logic [31:0] regdata,
                               input logic [4:0] rd);
    mw_t e;
    e = '0;
    e.v = 1'b1;
    e.op = op;
    e.f3 = f3;
    e.addr = addr;
    e.rdata = rdata;
    e.chk_rdata = chkr;
    e.regdata = regdata;
    e.rd = rd;
    return e;
  endfunction

  task automatic set_em(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rv2,
                        input logic [31:0] regdata, input logic [4:0] rd);
    EM_valid_out   = v;
    EM_op_out      = op;
    EM_funct3_out  = f3;
    EM_daddr_out   = addr;
    EM_rv2_out     = rv2;
    EM_regdata_out = regdata;
    EM_rd_out      = rd;
  endtask

  // Drive memory response for this cycle, record what MW_* must hold after
  // the edge, then move to mid-cycle so combinational outputs can be checked.
  task automatic drive(input logic dk, input logic [31:0] rdata, input mw_t e);
    dack   = dk;
    drdata = rdata;
    exp_q.push_back(e);
    #4;
  endtask

  // Cross the clock edge and compare the registered stage against the queue.
  task automatic settle();
    mw_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("mw_valid", MW_valid_out, e.v);
      chk("mem_fault", mem_fault, e.fault);
      if (e.v || e.full) begin
        chk("mw_op", MW_op_out, e.op);
        chk("mw_funct3", MW_funct3_out, e.f3);
        chk("mw_daddr", MW_daddr_out, e.addr);
        chk("mw_regdata", MW_regdata_out, e.regdata);
        chk("mw_rd", MW_rd_out, e.rd);
      end
      if (e.chk_rdata || e.full) chk("mw_drdata", MW_drdata_out, e.rdata);
    end
  endtask

  task automatic idle_cycle(input logic dk);
    set_em(1'b0, OP_ALU, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    drive(dk, 32'h5555AAAA, bub(1'b0));
    chk("idle_dreq", dreq, 1'b0);
    chk("idle_stall", mem_stall, 1'b0);
    settle();
  endtask

  initial begin
    reset = 1'b1;
    dack  = 1'b0;
    drdata = 32'd0;
    set_em(1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #4;
    chk("rst_dreq", dreq, 1'b0);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_fault", mem_fault, 1'b0);
    chk("rst_mw_valid", MW_valid_out, 1'b0);
    chk("rst_mw_regdata", MW_regdata_out, 32'd0);
    chk("rst_mw_drdata", MW_drdata_out, 32'd0);
    chk("rst_mw_rd", MW_rd_out, 5'd0);
    @(posedge clk);
    #1;

    // Non-memory pass-through
    set_em(1'b1, OP_ALU, 3'd0, 32'h0000_0000, 32'd0, 32'h12345678, 5'd5);
    drive(1'b0, 32'd0, live(OP_ALU, 3'd0, 32'h0, 32'h0, 1'b0, 32'h12345678, 5'd5));
    chk("alu_dreq", dreq, 1'b0);
    chk("alu_stall", mem_stall, 1'b0);
    settle();

    // Zero-wait LW
    set_em(1'b1, OP_LOAD, F3_W, 32'h100, 32'd0, 32'h0, 5'd7);
    drive(1'b1, 32'hDEADBEEF, live(OP_LOAD, F3_W, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0, 5'd7));
    chk("lw_dreq", dreq, 1'b1);
    chk("lw_stall", mem_stall, 1'b0);
    chk("lw_daddr", daddr, 32'h100);
    chk("lw_dwe", dwe, 4'b0000);
    settle();

    // SB with three wait states
    set_em(1'b1, OP_STORE, F3_B, 32'h203, 32'h000000AB, 32'h0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      drive(i == 3, 32'd0,
            (i == 3) ? live(OP_STORE, F3_B, 32'h203, 32'h0, 1'b0, 32'h0, 5'd0) : bub(1'b0));
      chk("sb_dreq", dreq, 1'b1);
      chk("sb_stall", mem_stall, i != 3);
      chk("sb_dwe", dwe, 4'b1000);
      chk("sb_dwdata", dwdata, 32'hABABABAB);
      chk("sb_daddr", daddr, 32'h200);
      settle();
    end
    // dack with no request in flight must be ignored
    idle_cycle(1'b1);

    // Zero-wait SH at a halfword-aligned upper address
    set_em(1'b1, OP_STORE, F3_H, 32'h402, 32'h1234BEEF, 32'h0, 5'd0);
    drive(1'b1, 32'd0, live(OP_STORE, F3_H, 32'h402, 32'h0, 1'b0, 32'h0, 5'd0));
    chk("sh_dwe", dwe, 4'b1100);
    chk("sh_dwdata", dwdata, 32'hBEEFBEEF);
    chk("sh_daddr", daddr, 32'h400);
    settle();

    // Misaligned LH: killed, one-cycle fault, no request, no stall
    set_em(1'b1, OP_LOAD, F3_H, 32'h101, 32'd0, 32'h0, 5'd9);
    drive(1'b0, 32'd0, bub(1'b1));
    chk("lh_mis_dreq", dreq, 1'b0);
    chk("lh_mis_stall", mem_stall, 1'b0);
    settle();
    idle_cycle(1'b0);

    // Illegal store funct3
    set_em(1'b1, OP_STORE, 3'b011, 32'h300, 32'd0, 32'h0, 5'd0);
    drive(1'b0, 32'd0, bub(1'b1));
    chk("st_ill_dreq", dreq, 1'b0);
    settle();
    idle_cycle(1'b0);

    // Timeout: LW never acknowledged
    set_em(1'b1, OP_LOAD, F3_W, 32'h40, 32'd0, 32'h0, 5'd4);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'd0, bub(i == 4));
      chk("to_dreq", dreq, 1'b1);
      chk("to_stall", mem_stall, i != 4);
      settle();
    end
    idle_cycle(1'b0);

    // Reset during the second WAIT cycle abandons the access
    set_em(1'b1, OP_LOAD, F3_W, 32'h80, 32'd0, 32'h0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) reset = 1'b1;
      drive(1'b0, 32'd0, (i == 2) ? zero_rec() : bub(1'b0));
      settle();
    end
    reset = 1'b0;
    idle_cycle(1'b0);

    // A later LW with one wait state completes normally
    set_em(1'b1, OP_LOAD, F3_W, 32'h84, 32'd0, 32'h0, 5'd6);
    drive(1'b0, 32'd0, bub(1'b0));
    chk("lw2_stall0", mem_stall, 1'b1);
    settle();
    drive(1'b1, 32'hCAFEF00D, live(OP_LOAD, F3_W, 32'h84, 32'hCAFEF00D, 1'b1, 32'h0, 5'd6));
    chk("lw2_stall1", mem_stall, 1'b0);
    settle();
    idle_cycle(1'b0);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline. Sits between the EX/MEM register (EM_* signals) and the writeback load-alignment logic, which consumes the MW_* signals.
- Issues load/store requests to the data memory through a req/ack handshake. Builds store lane data and byte enables, and checks alignment.
- Stalls the pipeline while memory is busy.
- Registers results into the MW_* pipeline register.

Parameters:
MAX_WAIT, 15, maximum cycles spent in WAIT before a memory timeout fault; must be >=1 and <=255.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
EM_valid_out  in  1  EX/MEM slot holds a live instruction
EM_op_out  in  7  opcode
EM_funct3_out  in  3  funct3
EM_daddr_out  in  32  effective address (ALU result)
EM_rv2_out  in  32  store source register value
EM_regdata_out  in  32  non-load writeback value
EM_rd_out  in  5  destination register
dreq  out  1  data memory request
daddr  out  32  word-aligned address, {EM_daddr_out[31:2],2'b00}
dwdata  out  32  lane-replicated store data
dwe  out  4  byte write enables; 0 for loads
drdata  in  32  raw memory read word
dack  in  1  memory completes the current request this cycle
mem_stall  out  1  hold IF/ID/EX and EM_* stable
mem_fault  out  1  one-cycle registered pulse on misalign, illegal funct3 or timeout
MW_valid_out  out  1  MEM/WB slot live
MW_op_out  out  7  registered opcode
MW_funct3_out  out  3  registered funct3
MW_daddr_out  out  32  registered full byte address
MW_drdata_out  out  32  registered raw read word (lane extraction is done downstream)
MW_regdata_out  out  32  registered EM_regdata_out
MW_rd_out  out  5  registered rd

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all MW_* = 0, state = IDLE, wait counter = 0, mem_fault = 0. dreq and mem_stall are combinational from state and are therefore 0 after reset.
- Mem op definitions:
  - load = opcode 0000011; store = opcode 0100011.
  - Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010.
- Alignment rules:
  - Halfword requires daddr[0]=0. Word requires daddr[1:0]=00.
  - A bad op is an illegal funct3 or a misaligned address.
- Store lanes:
  - SB: dwdata={4{rv2[7:0]}}, dwe=0001<<addr[1:0].
  - SH: dwdata={2{rv2[15:0]}}, dwe=0011<<addr[1:0].
  - SW: dwdata=rv2, dwe=1111.
- FSM states: IDLE, WAIT.
- IDLE, not valid or not a mem op:
  - No request. MW_* <= EM_*; MW_valid_out <= EM_valid_out.
  - Latency 1 cycle.
- IDLE, valid bad op:
  - No dreq. MW_valid_out <= 0 (instruction killed).
  - mem_fault <= 1 next cycle. No stall.
- IDLE, valid good op:
  - dreq=1 combinationally.
  - dack=1 same cycle: MW_* captured, including MW_drdata_out <= drdata. Stay IDLE, no stall (zero-wait memory gives 1-cycle latency).
  - dack=0: mem_stall=1 this cycle. MW_valid_out <= 0 (bubble). counter <= 1, go to WAIT.
- WAIT:
  - dreq=1, daddr/dwdata/dwe driven from the held EM_*. mem_stall=1 except in the completing cycle.
  - While waiting, MW_valid_out <= 0 each cycle, so no duplicate writeback occurs.
  - On dack: mem_stall=0, MW_* captured with MW_valid_out <= 1, go IDLE.
  - No dack and counter==MAX_WAIT: mem_stall=0 (releases the pipeline), MW_valid_out <= 0, mem_fault <= 1, go IDLE, counter <= 0. Otherwise counter increments.
- dack outside an active request is ignored.
- Reset during WAIT: next cycle IDLE and dreq=0; the in-flight access is abandoned.
- Counter is 8 bits wide. It saturates only via the MAX_WAIT check, so it never wraps.

Decomposition:
- Shared package rv32_pkg:
  - OP_LOAD, OP_STORE
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - FSM state encoding (IDLE=0, WAIT=1)
- One natural sub-module, store_lane_gen: combinational funct3 + addr[1:0] + rv2 -> dwdata, dwe, misaligned flag. It is also reusable by the bench model.

Test Plan:
- Non-mem pass-through: EM_valid_out=1, op=0110011, regdata=0x12345678, rd=5 -> next cycle MW_valid_out=1, MW_regdata_out=0x12345678, MW_rd_out=5, dreq never 1.
- Zero-wait LW: addr=0x100, dack=1 with the request, drdata=0xDEADBEEF -> mem_stall=0, next cycle MW_drdata_out=0xDEADBEEF, MW_valid_out=1.
- SB with 3 wait states: addr=0x203, rv2=0x000000AB, dack on the 4th request cycle -> dreq high 4 cycles, dwe=1000, dwdata=0xABABABAB, daddr=0x200, mem_stall high for the first 3 cycles, exactly one MW_valid_out=1 pulse.
- Misaligned LH at addr=0x101 -> dreq=0, next cycle mem_fault=1 for one cycle, MW_valid_out=0, no stall.
- Timeout with MAX_WAIT=4: LW, dack held 0 -> dreq high 5 cycles, mem_stall released in the 5th, mem_fault=1 next cycle, MW_valid_out=0.
- Reset asserted in the 2nd WAIT cycle -> next cycle dreq=0, mem_stall=0, all MW_*=0; a later LW completes normally.
